// File: rtl/cpu_mem_bridge_pkg.sv
// Shared definitions for the CPU-to-memory bridge: FSM state encoding,
// channel owner encoding, access size codes and the debug view struct.
package cpu_mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Debug view: FSM state, owner of the current/last transaction and the
  // arbiter's last-winner flag.
  typedef struct packed {
    state_e state;
    logic   owner;
    logic   last_owner;
  } bridge_dbg_t;

endpackage

// File: rtl/cpu_mem_bridge_arbiter.sv
// Two-input grant generator for the bridge. Default build: fixed priority,
// data beats inst. With BRIDGE_RR_ARB_EN defined: round-robin, the channel
// that did not win the last accepted grant wins a tie.
module bridge_arbiter
  import cpu_mem_bridge_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic req_inst,
  input  logic req_data,
  input  logic accept,
  output logic gnt_inst,
  output logic gnt_data,
  output logic last_owner
);

  logic last_q;
  logic last_d;
  logic prefer_data;

  // Grant selection and last-winner update on each accepted request.
  always_comb begin
`ifdef BRIDGE_RR_ARB_EN
    prefer_data = (last_q == OWN_INST);
`else
    prefer_data = 1'b1;
`endif
    gnt_data = req_data & (prefer_data | ~req_inst);
    gnt_inst = req_inst & ~gnt_data;
    last_d   = last_q;
    if (accept) begin
      last_d = gnt_data ? OWN_DATA : OWN_INST;
    end
  end

  // Last-winner flag; resets to inst so data wins the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_q <= OWN_INST;
    end else begin
      last_q <= last_d;
    end
  end

  assign last_owner = last_q;

endmodule

// File: rtl/cpu_mem_bridge.sv
// Bridges the core's inst and data sram-like ports onto one valid/ready
// memory bus with a single outstanding transaction.
// Optional macro: BRIDGE_RR_ARB_EN selects round-robin arbitration.
//
// Handshakes: a channel request is taken in the IDLE cycle its addr_ok is
// high (combinational, at most one channel per cycle). The memory request is
// transferred on the rising edge where mem_req_valid && mem_req_ready; the
// request fields stay frozen from accept until then. mem_resp_valid is
// always accepted but only acts in RESP. data_ok is a one-cycle pulse to
// the owning channel, for reads and writes alike.
module cpu_mem_bridge
  import cpu_mem_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_wr,
  output logic [1:0]          mem_req_size,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata,
  output bridge_dbg_t         dbg
);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                wr_q, wr_d;
  logic [1:0]          size_q, size_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                req_valid_q, req_valid_d;
  logic                inst_ok_q, inst_ok_d;
  logic                data_ok_q, data_ok_d;
  logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;

  logic idle;
  logic gnt_inst;
  logic gnt_data;
  logic last_owner;

  // Requests are only visible to the arbiter in IDLE and out of reset, so
  // addr_ok drops at once when resetn falls.
  assign idle = resetn && (state_q == IDLE);

  bridge_arbiter u_arb (
    .clk        (clk),
    .resetn     (resetn),
    .req_inst   (inst_req & idle),
    .req_data   (data_req & idle),
    .accept     (gnt_inst | gnt_data),
    .gnt_inst   (gnt_inst),
    .gnt_data   (gnt_data),
    .last_owner (last_owner)
  );

  // Next-state, request latch, response capture and registered strobes.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wr_d         = wr_q;
    size_d       = size_q;
    wstrb_d      = wstrb_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_data) begin
          owner_d = OWN_DATA;
          wr_d    = data_wr;
          size_d  = data_size;
          wstrb_d = data_wstrb;
          addr_d  = data_addr;
          wdata_d = data_wdata;
          state_d = REQ;
        end else if (gnt_inst) begin
          owner_d = OWN_INST;
          wr_d    = inst_wr;
          size_d  = inst_size;
          wstrb_d = inst_wstrb;
          addr_d  = inst_addr;
          wdata_d = inst_wdata;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) state_d = RESP;
      end
      RESP: begin
        if (mem_resp_valid) begin
          state_d = DONE;
          // Writes complete without touching the channel's read data.
          if (!wr_q) begin
            if (owner_q == OWN_DATA) data_rdata_d = mem_resp_rdata;
            else                     inst_rdata_d = mem_resp_rdata;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    req_valid_d = (state_d == REQ);
    inst_ok_d   = (state_d == DONE) && (owner_d == OWN_INST);
    data_ok_d   = (state_d == DONE) && (owner_d == OWN_DATA);
  end

  // Single state register for the FSM and all of its registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      owner_q      <= OWN_INST;
      wr_q         <= 1'b0;
      size_q       <= '0;
      wstrb_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_valid_q  <= 1'b0;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      wstrb_q      <= wstrb_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_valid_q  <= req_valid_d;
      inst_ok_q    <= inst_ok_d;
      data_ok_q    <= data_ok_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign inst_addr_ok   = gnt_inst;
  assign data_addr_ok   = gnt_data;
  assign inst_data_ok   = inst_ok_q;
  assign data_data_ok   = data_ok_q;
  assign inst_rdata     = inst_rdata_q;
  assign data_rdata     = data_rdata_q;
  assign mem_req_valid  = req_valid_q;
  assign mem_req_wr     = wr_q;
  assign mem_req_size   = size_q;
  assign mem_req_wstrb  = wstrb_q;
  assign mem_req_addr   = addr_q;
  assign mem_req_wdata  = wdata_q;
  assign dbg.state      = state_q;
  assign dbg.owner      = owner_q;
  assign dbg.last_owner = last_owner;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Self-checking bench for cpu_mem_bridge: directed scenarios plus a
// randomized transaction stream against a transaction-level model.
`timescale 1ns/1ps
module tb_cpu_mem_bridge;
  import cpu_mem_bridge_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
`ifdef BRIDGE_RR_ARB_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          inst_req, inst_wr, data_req, data_wr;
  logic [1:0]    inst_size, data_size;
  logic [SW-1:0] inst_wstrb, data_wstrb;
  logic [AW-1:0] inst_addr, data_addr;
  logic [DW-1:0] inst_wdata, data_wdata;
  logic          inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [DW-1:0] inst_rdata, data_rdata;
  logic          mem_req_valid, mem_req_ready, mem_req_wr;
  logic [1:0]    mem_req_size;
  logic [SW-1:0] mem_req_wstrb;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_rdata;
  bridge_dbg_t   dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_inst_rdata, exp_data_rdata;

  // Clock and watchdog
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  cpu_mem_bridge #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wr(mem_req_wr),
    .mem_req_size(mem_req_size), .mem_req_wstrb(mem_req_wstrb), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .dbg(dbg)
  );

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0;
  endtask

  task automatic drive_req(input bit ch, input logic wr, input logic [1:0] sz,
                           input logic [SW-1:0] st, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    if (ch) begin
      data_req = 1; data_wr = wr; data_size = sz; data_wstrb = st; data_addr = ad; data_wdata = wd;
    end else begin
      inst_req = 1; inst_wr = wr; inst_size = sz; inst_wstrb = st; inst_addr = ad; inst_wdata = wd;
    end
  endtask

  // Drop requests and garble the fields so only latched values can reach the bus.
  task automatic scramble_req();
    inst_req = 0; data_req = 0;
    inst_wr = 1'($urandom); inst_size = 2'($urandom); inst_wstrb = SW'($urandom);
    inst_addr = AW'($urandom); inst_wdata = DW'($urandom);
    data_wr = 1'($urandom); data_size = 2'($urandom); data_wstrb = SW'($urandom);
    data_addr = AW'($urandom); data_wdata = DW'($urandom);
  endtask

  // Runs one request through the bridge acting as a memory with the given
  // ready and response delays; returns observations only.
  task automatic run_txn(input bit ch, input logic wr, input logic [1:0] sz, input logic [SW-1:0] st,
                         input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                         input int rdy_dly, input int rsp_dly, input logic [DW-1:0] rsp,
                         output bit acc_ok, output bit fld_ok, output int n_ok_i, output int n_ok_d,
                         output int lat);
    int c;
    acc_ok = 0; fld_ok = 1; n_ok_i = 0; n_ok_d = 0; lat = -1; c = 0;
    mem_req_ready = 0; mem_resp_valid = 0;
    @(negedge clk);
    drive_req(ch, wr, sz, st, ad, wd);
    #1;
    acc_ok = ch ? (data_addr_ok === 1'b1 && inst_addr_ok === 1'b0)
                : (inst_addr_ok === 1'b1 && data_addr_ok === 1'b0);
    @(negedge clk); c = 1;
    scramble_req();
    for (int k = 0; k <= rdy_dly; k++) begin
      if (mem_req_valid !== 1'b1 || mem_req_wr !== wr || mem_req_size !== sz || mem_req_wstrb !== st ||
          mem_req_addr !== ad || mem_req_wdata !== wd) fld_ok = 0;
      n_ok_i += int'(inst_data_ok); n_ok_d += int'(data_data_ok);
      mem_req_ready = (k == rdy_dly);
      @(negedge clk); c++;
    end
    mem_req_ready = 0;
    for (int k = 0; k <= rsp_dly; k++) begin
      if (mem_req_valid !== 1'b0) fld_ok = 0;
      n_ok_i += int'(inst_data_ok); n_ok_d += int'(data_data_ok);
      mem_resp_valid = (k == rsp_dly);
      mem_resp_rdata = (k == rsp_dly) ? rsp : DW'($urandom);
      @(negedge clk); c++;
    end
    mem_resp_valid = 0; mem_resp_rdata = DW'($urandom);
    for (int k = 0; k < 3; k++) begin
      if ((inst_data_ok === 1'b1 || data_data_ok === 1'b1) && lat < 0) lat = c;
      n_ok_i += int'(inst_data_ok); n_ok_d += int'(data_data_ok);
      @(negedge clk); c++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    resetn = 0;
    inst_req = 1; data_req = 1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (inst_addr_ok !== 1'b0) begin n_errors++; $display("FAIL reset_inst_addr_ok: got %0b expected 0", inst_addr_ok); end
    n_checks++; if (data_addr_ok !== 1'b0) begin n_errors++; $display("FAIL reset_data_addr_ok: got %0b expected 0", data_addr_ok); end
    n_checks++; if (mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL reset_mem_req_valid: got %0b expected 0", mem_req_valid); end
    n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin n_errors++; $display("FAIL reset_data_ok: got %0b%0b expected 00", inst_data_ok, data_data_ok); end
    n_checks++; if ({inst_rdata, data_rdata} !== 64'h0) begin n_errors++; $display("FAIL reset_rdata: got %0h/%0h expected 0/0", inst_rdata, data_rdata); end
    n_checks++; if ({mem_req_wr, mem_req_size, mem_req_wstrb, mem_req_addr, mem_req_wdata} !== '0) begin n_errors++; $display("FAIL reset_mem_fields: got addr %0h wdata %0h expected 0", mem_req_addr, mem_req_wdata); end
    n_checks++; if (dbg !== '0) begin n_errors++; $display("FAIL reset_dbg: got %0h expected 0", dbg); end
    inst_req = 0; data_req = 0;
    @(negedge clk); resetn = 1;
    exp_inst_rdata = '0; exp_data_rdata = '0;
  endtask

  task automatic test_inst_read();
    @(negedge clk);
    drive_req(0, 1'b0, SZ_WORD, 4'hF, 32'h1C000000, 32'h0);
    #1;
    n_checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin n_errors++; $display("FAIL inst_read_addr_ok: got %0b%0b expected 10", inst_addr_ok, data_addr_ok); end
    n_checks++; if (mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL inst_read_valid_T: got %0b expected 0", mem_req_valid); end
    @(negedge clk); scramble_req(); mem_req_ready = 1;
    n_checks++; if (mem_req_valid !== 1'b1) begin n_errors++; $display("FAIL inst_read_valid_T1: got %0b expected 1", mem_req_valid); end
    n_checks++; if (mem_req_addr !== 32'h1C000000 || mem_req_wr !== 1'b0) begin n_errors++; $display("FAIL inst_read_addr: got %0h wr %0b expected 1c000000 wr 0", mem_req_addr, mem_req_wr); end
    @(negedge clk); mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h02800C04;
    n_checks++; if ({mem_req_valid, inst_data_ok} !== 2'b00) begin n_errors++; $display("FAIL inst_read_T2: got valid %0b ok %0b expected 0 0", mem_req_valid, inst_data_ok); end
    @(negedge clk); mem_resp_valid = 0; mem_resp_rdata = 32'h0;
    n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin n_errors++; $display("FAIL inst_read_data_ok_T3: got %0b%0b expected 10", inst_data_ok, data_data_ok); end
    n_checks++; if (inst_rdata !== 32'h02800C04) begin n_errors++; $display("FAIL inst_read_rdata: got %0h expected 02800c04", inst_rdata); end
    exp_inst_rdata = 32'h02800C04;
    @(negedge clk);
    n_checks++; if (inst_data_ok !== 1'b0 || inst_rdata !== exp_inst_rdata) begin n_errors++; $display("FAIL inst_read_T4: got ok %0b rdata %0h expected 0 %0h", inst_data_ok, inst_rdata, exp_inst_rdata); end
  endtask

  task automatic test_data_write_stall();
    bit acc_ok, fld_ok; int n_i, n_d, lat;
    run_txn(1, 1'b1, SZ_HALF, 4'b0011, 32'h00001000, 32'hDEADBEEF, 5, 1, 32'h5555AAAA,
            acc_ok, fld_ok, n_i, n_d, lat);
    n_checks++; if (!acc_ok) begin n_errors++; $display("FAIL wr_stall_accept: got 0 expected 1"); end
    n_checks++; if (!fld_ok) begin n_errors++; $display("FAIL wr_stall_fields_stable: got 0 expected 1"); end
    n_checks++; if (n_d != 1 || n_i != 0) begin n_errors++; $display("FAIL wr_stall_data_ok: got data %0d inst %0d expected 1 0", n_d, n_i); end
    n_checks++; if (lat != 9) begin n_errors++; $display("FAIL wr_stall_latency: got %0d expected 9", lat); end
    n_checks++; if (data_rdata !== exp_data_rdata) begin n_errors++; $display("FAIL wr_stall_rdata_held: got %0h expected %0h", data_rdata, exp_data_rdata); end
    n_checks++; if (inst_rdata !== exp_inst_rdata) begin n_errors++; $display("FAIL wr_stall_inst_rdata: got %0h expected %0h", inst_rdata, exp_inst_rdata); end
  endtask

  // Both channels hold requests with two transactions each; memory answers at once.
  task automatic test_back_to_back();
    int pend_i = 2, pend_d = 2, grants = 0, last_cyc = -100, cyc = 0;
    bit last_data = 1'b0;
    bit exp_d;
    @(negedge clk);
    inst_wr = 0; inst_size = SZ_WORD; inst_wstrb = 4'hF; inst_addr = 32'h1C000100; inst_wdata = 0;
    data_wr = 0; data_size = SZ_WORD; data_wstrb = 4'hF; data_addr = 32'h00002000; data_wdata = 0;
    mem_req_ready = 1; mem_resp_valid = 1;
    while ((grants < 4 || cyc < last_cyc + 4) && cyc < 80) begin
      @(negedge clk); cyc++;
      inst_req = (pend_i > 0); data_req = (pend_d > 0);
      mem_resp_rdata = 32'hA0000000 + DW'(cyc);
      #1;
      if (inst_addr_ok === 1'b1 || data_addr_ok === 1'b1) begin
        if (pend_i > 0 && pend_d > 0) exp_d = RR_MODE ? !last_data : 1'b1;
        else exp_d = (pend_d > 0);
        n_checks++; if ({data_addr_ok, inst_addr_ok} !== {exp_d, !exp_d}) begin n_errors++; $display("FAIL tie_grant_%0d: got data %0b inst %0b expected data %0b", grants, data_addr_ok, inst_addr_ok, exp_d); end
        if (grants > 0) begin
          n_checks++; if (cyc - last_cyc != 4) begin n_errors++; $display("FAIL tie_spacing_%0d: got %0d expected 4", grants, cyc - last_cyc); end
        end
        if (exp_d) begin pend_d--; exp_data_rdata = 32'hA0000000 + DW'(cyc + 2); end
        else begin pend_i--; exp_inst_rdata = 32'hA0000000 + DW'(cyc + 2); end
        last_data = exp_d; grants++; last_cyc = cyc;
      end
    end
    idle_inputs();
    n_checks++; if (grants != 4) begin n_errors++; $display("FAIL tie_grant_count: got %0d expected 4", grants); end
    n_checks++; if (inst_rdata !== exp_inst_rdata || data_rdata !== exp_data_rdata) begin n_errors++; $display("FAIL tie_rdata: got %0h/%0h expected %0h/%0h", inst_rdata, data_rdata, exp_inst_rdata, exp_data_rdata); end
  endtask

  task automatic test_spurious_resp();
    bit acc_ok, fld_ok; int n_i, n_d, lat;
    int stray = 0;
    @(negedge clk);
    mem_resp_valid = 1;
    for (int k = 0; k < 3; k++) begin
      mem_resp_rdata = DW'($urandom);
      @(negedge clk);
      stray += int'(inst_data_ok) + int'(data_data_ok);
    end
    mem_resp_valid = 0;
    n_checks++; if (stray != 0) begin n_errors++; $display("FAIL spurious_data_ok: got %0d expected 0", stray); end
    n_checks++; if (inst_rdata !== exp_inst_rdata || data_rdata !== exp_data_rdata) begin n_errors++; $display("FAIL spurious_rdata: got %0h/%0h expected %0h/%0h", inst_rdata, data_rdata, exp_inst_rdata, exp_data_rdata); end
    n_checks++; if (dbg.state !== IDLE || mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL spurious_state: got %0d valid %0b expected 0 0", dbg.state, mem_req_valid); end
    run_txn(0, 1'b0, SZ_WORD, 4'hF, 32'h1C000010, 32'h0, 0, 0, 32'h13572468, acc_ok, fld_ok, n_i, n_d, lat);
    exp_inst_rdata = 32'h13572468;
    n_checks++; if (!acc_ok || lat != 3 || n_i != 1) begin n_errors++; $display("FAIL spurious_followup: got acc %0b lat %0d oks %0d expected 1 3 1", acc_ok, lat, n_i); end
  endtask

  task automatic test_long_wait();
    int stray = 0, n_d = 0;
    @(negedge clk);
    drive_req(1, 1'b0, SZ_WORD, 4'hF, 32'h00002000, 32'h0);
    #1;
    n_checks++; if (data_addr_ok !== 1'b1) begin n_errors++; $display("FAIL long_accept: got %0b expected 1", data_addr_ok); end
    @(negedge clk); scramble_req();
    drive_req(0, 1'b0, SZ_WORD, 4'hF, 32'h1C003000, 32'h0);
    mem_req_ready = 1;
    #1; stray += int'(inst_addr_ok) + int'(data_addr_ok);
    @(negedge clk); mem_req_ready = 0;
    for (int k = 0; k <= 20; k++) begin
      #1; stray += int'(inst_addr_ok) + int'(data_addr_ok); n_d += int'(data_data_ok);
      mem_resp_valid = (k == 20);
      mem_resp_rdata = (k == 20) ? 32'hC0FFEE01 : DW'($urandom);
      @(negedge clk);
    end
    mem_resp_valid = 0;
    #1; stray += int'(inst_addr_ok) + int'(data_addr_ok); n_d += int'(data_data_ok);
    exp_data_rdata = 32'hC0FFEE01;
    n_checks++; if (data_rdata !== exp_data_rdata) begin n_errors++; $display("FAIL long_rdata: got %0h expected %0h", data_rdata, exp_data_rdata); end
    @(negedge clk); #1;
    n_d += int'(data_data_ok);
    n_checks++; if (stray != 0) begin n_errors++; $display("FAIL long_addr_ok_while_busy: got %0d expected 0", stray); end
    n_checks++; if (n_d != 1) begin n_errors++; $display("FAIL long_data_ok_count: got %0d expected 1", n_d); end
    n_checks++; if (inst_addr_ok !== 1'b1) begin n_errors++; $display("FAIL long_inst_accept_idle: got %0b expected 1", inst_addr_ok); end
    @(negedge clk); scramble_req(); mem_req_ready = 1;
    @(negedge clk); mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h600DF00D;
    @(negedge clk); mem_resp_valid = 0;
    exp_inst_rdata = 32'h600DF00D;
    n_checks++; if (inst_data_ok !== 1'b1 || inst_rdata !== exp_inst_rdata) begin n_errors++; $display("FAIL long_inst_done: got ok %0b rdata %0h expected 1 %0h", inst_data_ok, inst_rdata, exp_inst_rdata); end
  endtask

  task automatic test_reset_mid_op();
    bit acc_ok, fld_ok; int n_i, n_d, lat;
    int late = 0;
    // Reset while the memory request is being presented.
    @(negedge clk);
    drive_req(0, 1'b0, SZ_WORD, 4'hF, 32'h1C000040, 32'h0);
    @(negedge clk); scramble_req();
    #2; resetn = 0; #1;
    n_checks++; if (mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL rst_req_valid_async: got %0b expected 0", mem_req_valid); end
    @(negedge clk); resetn = 1;
    // Reset while waiting for the response.
    @(negedge clk);
    drive_req(0, 1'b0, SZ_WORD, 4'hF, 32'h1C000044, 32'h0);
    @(negedge clk); scramble_req(); mem_req_ready = 1;
    @(negedge clk); mem_req_ready = 0;
    #2; resetn = 0; #1;
    exp_inst_rdata = '0; exp_data_rdata = '0;
    n_checks++; if ({mem_req_valid, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin n_errors++; $display("FAIL rst_resp_outputs: got %0b expected 0", {mem_req_valid, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
    n_checks++; if (dbg !== '0 || inst_rdata !== 32'h0 || mem_req_addr !== 32'h0) begin n_errors++; $display("FAIL rst_resp_state: got dbg %0h rdata %0h addr %0h expected 0", dbg, inst_rdata, mem_req_addr); end
    @(negedge clk); resetn = 1;
    @(negedge clk); mem_resp_valid = 1; mem_resp_rdata = 32'hBAD0BAD0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); mem_resp_valid = 0;
      late += int'(inst_data_ok) + int'(data_data_ok);
    end
    n_checks++; if (late != 0 || inst_rdata !== exp_inst_rdata) begin n_errors++; $display("FAIL rst_late_resp: got oks %0d rdata %0h expected 0 %0h", late, inst_rdata, exp_inst_rdata); end
    run_txn(0, 1'b0, SZ_WORD, 4'hF, 32'h1C000048, 32'h0, 0, 0, 32'h0ACE0ACE, acc_ok, fld_ok, n_i, n_d, lat);
    exp_inst_rdata = 32'h0ACE0ACE;
    n_checks++; if (!acc_ok || !fld_ok || lat != 3 || n_i != 1 || n_d != 0) begin n_errors++; $display("FAIL rst_followup: got acc %0b fld %0b lat %0d oks %0d/%0d expected 1 1 3 1/0", acc_ok, fld_ok, lat, n_i, n_d); end
    n_checks++; if (inst_rdata !== exp_inst_rdata) begin n_errors++; $display("FAIL rst_followup_rdata: got %0h expected %0h", inst_rdata, exp_inst_rdata); end
  endtask

  // Random single-channel transactions with random stalls; the model keeps
  // each channel's last read value and queues the owner's expected rdata.
  task automatic test_random();
    bit acc_ok, fld_ok; int n_i, n_d, lat;
    bit ch; logic wr; logic [1:0] sz; logic [SW-1:0] st; logic [AW-1:0] ad; logic [DW-1:0] wd, rsp, exp_v;
    int rdy, rsd;
    for (int t = 0; t < 30; t++) begin
      ch = 1'($urandom_range(0, 1));
      wr = ch ? 1'($urandom_range(0, 1)) : 1'b0;
      sz = 2'($urandom_range(0, 2));
      st = SW'($urandom);
      ad = AW'($urandom);
      wd = DW'($urandom);
      rsp = DW'($urandom);
      rdy = $urandom_range(0, 3);
      rsd = $urandom_range(0, 3);
      if (ch) exp_q.push_back(wr ? exp_data_rdata : rsp);
      else    exp_q.push_back(rsp);
      run_txn(ch, wr, sz, st, ad, wd, rdy, rsd, rsp, acc_ok, fld_ok, n_i, n_d, lat);
      exp_v = exp_q.pop_front();
      if (ch) exp_data_rdata = exp_v; else exp_inst_rdata = exp_v;
      n_checks++; if (!acc_ok) begin n_errors++; $display("FAIL rand%0d_accept: got 0 expected 1 (ch %0d)", t, ch); end
      n_checks++; if (!fld_ok) begin n_errors++; $display("FAIL rand%0d_fields: got 0 expected 1", t); end
      n_checks++; if (n_i != (ch ? 0 : 1) || n_d != (ch ? 1 : 0)) begin n_errors++; $display("FAIL rand%0d_data_ok: got inst %0d data %0d expected ch %0d only", t, n_i, n_d, ch); end
      n_checks++; if (lat != rdy + rsd + 3) begin n_errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", t, lat, rdy + rsd + 3); end
      n_checks++; if (inst_rdata !== exp_inst_rdata) begin n_errors++; $display("FAIL rand%0d_inst_rdata: got %0h expected %0h", t, inst_rdata, exp_inst_rdata); end
      n_checks++; if (data_rdata !== exp_data_rdata) begin n_errors++; $display("FAIL rand%0d_data_rdata: got %0h expected %0h", t, data_rdata, exp_data_rdata); end
    end
  endtask

  initial begin
    test_reset();
    test_inst_read();
    test_data_write_stall();
    test_back_to_back();
    test_spurious_resp();
    test_long_wait();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
